hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-issue hazard detector: tracks every in-flight instruction's destination register, load flag and memory address in a DEPTH-entry shift scoreboard.
- Issues PC stall, bubble and branch-shadow squash decisions for the decode stage.
- Supports full-stall mode and forwarding mode, where only load-use stalls. Also supports a programmable branch-shadow length, a pipeline flush, and a saturating stall-statistics counter.
- Sits between fetch/decode and the pipeline register control.

Parameters:
- RIDX_W, 3, register index width (8 GPRs).
- DEPTH, 4, number of tracked stages after decode (ID/EX, EX/MEM, MEM/WB, WB).
- FWD_EN, 0, 0 = stall on any RAW match in scoreboard; 1 = stall only on load-use (match against entry 0 that is a load).
- ADDR_W, 16, memory address width.
- MEM_WIN, 2, number of youngest entries checked for store->load address hazard (1..DEPTH).
- BR_SHADOW, 1, squash cycles after a control instruction issues (0 disables).
- CNT_W, 16, stall statistics counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode holds a real instruction this cycle.
- rs_idx  in  RIDX_W  source 1 index.
- rs_used  in  1  rs read by instruction.
- rt_idx  in  RIDX_W  source 2 index.
- rt_used  in  1  rt read by instruction.
- rd_idx  in  RIDX_W  destination index.
- rd_wr  in  1  instruction writes rd.
- is_load  in  1  memory read.
- is_store  in  1  memory write.
- mem_addr  in  ADDR_W  effective address (valid when is_load|is_store).
- is_ctrl  in  1  jump/branch.
- flush  in  1  redirect from later stage; kill scoreboard and shadow.
- stall  out  1  hold PC and IF/ID register.
- bubble  out  1  inject NOP into ID/EX.
- squash  out  1  current decode instruction is in branch shadow and discarded.
- stall_cnt  out  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- Reset (async, rst_n=0):
  - All scoreboard entries invalid; shadow counter = 0; stall_cnt = 0.
  - stall/bubble/squash therefore 0.
- Scoreboard entry fields: {valid, rd, rd_wr, load, store, addr}.
- Scoreboard shift (every clock):
  - entry[k+1] <= entry[k] for k < DEPTH-1; entry[DEPTH-1] drops.
  - entry[0] <= decode instruction if issue_valid & ~stall & ~squash & ~flush, else invalid bubble.
- reg_haz: for each source (rs with rs_used, rt with rt_used), a match is a valid entry with rd_wr and rd == source.
  - FWD_EN=0: any match in entries 0..DEPTH-1.
  - FWD_EN=1: a match only in entry 0 and only if entry 0 is a load.
- mem_haz: issue is_load and a valid store entry among entries 0..MEM_WIN-1 has an equal addr.
  - No mem_haz for store-after-store or store-after-load.
- Outputs (all combinational from current inputs and state):
  - squash = issue_valid & (shadow != 0) & ~flush.
  - stall = issue_valid & ~squash & ~flush & (reg_haz | mem_haz).
  - bubble = stall | squash.
- Shadow counter:
  - Loads BR_SHADOW when a control instruction is accepted (issue_valid & is_ctrl & ~stall & ~squash & ~flush).
  - Otherwise decrements each cycle while nonzero; counts cycles whether or not issue_valid.
  - A stalled control instruction does not load the counter until it is accepted.
- flush:
  - Entries 0..DEPTH-1 all invalid next cycle; shadow = 0 next cycle.
  - All outputs 0 in the flush cycle; flush overrides any hazard.
- stall_cnt increments on each cycle with stall=1 and saturates at all-ones; it is not cleared by flush.
- Hazard persistence: a stalled instruction re-evaluates every cycle. The stall clears once the producing entry shifts past DEPTH-1 (FWD_EN=0) or past entry 0 (FWD_EN=1).
  - Maximum stall duration is DEPTH cycles (FWD_EN=0) or 1 cycle (FWD_EN=1).
- Self-dependence: an instruction with rd == rs does not hazard on itself.
- Instructions with rs_used=rt_used=0 never report reg_haz.

Test Plan:
- FWD_EN=0, DEPTH=4: issue ADD rd=3, then an instruction reading rs=3 -> stall=1 and bubble=1 for 4 cycles, stall=0 on the 5th; stall_cnt=4.
- FWD_EN=1: LOAD rd=2, then an instruction with rt=2 -> stall=1 for exactly 1 cycle. Same case with ADD rd=2 -> stall never asserts.
- MEM_WIN=2: STORE addr 0x0040, then LOAD addr 0x0040 -> stall=1. Same pair with LOAD addr 0x0042 -> stall=0.
- BR_SHADOW=2: accept a branch, then 2 valid instructions -> squash=1, bubble=1, stall=0 on both. Third instruction is accepted normally.
- Hazard pending (stall=1) with flush=1 in the same cycle -> all outputs 0. Next cycle the same reader issues with no stall (scoreboard empty).
- Force 2^CNT_W+3 stall cycles (CNT_W reduced to 4) -> stall_cnt holds 0xF. Assert rst_n=0 mid-stall -> outputs and stall_cnt 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode-side handshake between fetch/decode and the hazard scoreboard.
// master = decode stage driving the instruction, slave = scoreboard.
interface hazard_scoreboard_if #(
   parameter int RIDX_W = 3,
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 16
);
   logic              issue_valid;
   logic [RIDX_W-1:0] rs_idx;
   logic              rs_used;
   logic [RIDX_W-1:0] rt_idx;
   logic              rt_used;
   logic [RIDX_W-1:0] rd_idx;
   logic              rd_wr;
   logic              is_load;
   logic              is_store;
   logic [ADDR_W-1:0] mem_addr;
   logic              is_ctrl;
   logic              flush;
   logic              stall;
   logic              bubble;
   logic              squash;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output issue_valid, rs_idx, rs_used, rt_idx, rt_used, rd_idx, rd_wr,
             is_load, is_store, mem_addr, is_ctrl, flush,
      input  stall, bubble, squash, stall_cnt
   );

   modport slave (
      input  issue_valid, rs_idx, rs_used, rt_idx, rt_used, rd_idx, rd_wr,
             is_load, is_store, mem_addr, is_ctrl, flush,
      output stall, bubble, squash, stall_cnt
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: shift register of in-flight instructions driving
// PC stall, ID/EX bubble and branch-shadow squash, plus a saturating stall counter.
module hazard_scoreboard #(
   parameter int RIDX_W    = 3,
   parameter int DEPTH     = 4,
   parameter int FWD_EN    = 0,
   parameter int ADDR_W    = 16,
   parameter int MEM_WIN   = 2,
   parameter int BR_SHADOW = 1,
   parameter int CNT_W     = 16
) (
   input logic                clk,
   input logic                rst_n,
   hazard_scoreboard_if.slave bus
);
   localparam int SH_W = (BR_SHADOW > 0) ? $clog2(BR_SHADOW + 1) : 1;

   typedef struct packed {
      logic              valid;
      logic [RIDX_W-1:0] rd;
      logic              rd_wr;
      logic              load;
      logic              store;
      logic [ADDR_W-1:0] addr;
   } entry_t;

   entry_t            sb [DEPTH];
   entry_t            issue_entry;
   logic [SH_W-1:0]   shadow;
   logic [CNT_W-1:0]  stall_cnt_q;
   logic              reg_haz;
   logic              mem_haz;
   logic              squash_c;
   logic              stall_c;
   logic              accept;

   // In forwarding mode only a load sitting in entry 0 can't be bypassed in time.
   always_comb begin
      reg_haz = 1'b0;
      mem_haz = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (sb[k].valid && sb[k].rd_wr && ((FWD_EN == 0) || (k == 0 && sb[k].load))) begin
            if (bus.rs_used && (sb[k].rd == bus.rs_idx)) reg_haz = 1'b1;
            if (bus.rt_used && (sb[k].rd == bus.rt_idx)) reg_haz = 1'b1;
         end
         if ((k < MEM_WIN) && bus.is_load && sb[k].valid && sb[k].store &&
             (sb[k].addr == bus.mem_addr))
            mem_haz = 1'b1;
      end
   end

   always_comb begin
      squash_c = bus.issue_valid && (shadow != '0) && !bus.flush;
      stall_c  = bus.issue_valid && !squash_c && !bus.flush && (reg_haz || mem_haz);
      accept   = bus.issue_valid && !stall_c && !squash_c && !bus.flush;
   end

   always_comb begin
      issue_entry       = '0;
      issue_entry.valid = 1'b1;
      issue_entry.rd    = bus.rd_idx;
      issue_entry.rd_wr = bus.rd_wr;
      issue_entry.load  = bus.is_load;
      issue_entry.store = bus.is_store;
      issue_entry.addr  = bus.mem_addr;
   end

   assign bus.stall     = stall_c;
   assign bus.squash    = squash_c;
   assign bus.bubble    = stall_c || squash_c;
   assign bus.stall_cnt = stall_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) sb[k] <= '0;
         shadow      <= '0;
         stall_cnt_q <= '0;
      end else begin
         sb[0] <= accept ? issue_entry : '0;
         for (int k = 1; k < DEPTH; k++) sb[k] <= bus.flush ? '0 : sb[k-1];

         // A stalled branch only opens its shadow once it is actually accepted.
         if (bus.flush)
            shadow <= '0;
         else if (accept && bus.is_ctrl)
            shadow <= SH_W'(BR_SHADOW);
         else if (shadow != '0)
            shadow <= shadow - 1'b1;

         if (stall_c && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two configurations driven in lockstep and checked
// against a queue-based reference model, a vector table and hand-written corner cases.
module tb_hazard_scoreboard;
   localparam int DEPTH = 4;

   typedef struct {
      bit iv; int rs; bit rsu; int rt; bit rtu; int rd; bit wr;
      bit ld; bit st; int addr; bit ctrl; bit fl;
   } stim_t;

   typedef struct {
      bit valid; int rd; bit wr; bit ld; bit st; int addr;
   } rec_t;

   typedef struct {
      stim_t s; bit st0; bit sq0; bit st1; bit sq1; int c0; int c1;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_scoreboard_if #(.RIDX_W(3), .ADDR_W(16), .CNT_W(4))  if0 ();
   hazard_scoreboard_if #(.RIDX_W(3), .ADDR_W(16), .CNT_W(16)) if1 ();

   hazard_scoreboard #(.DEPTH(DEPTH), .FWD_EN(0), .MEM_WIN(2), .BR_SHADOW(2), .CNT_W(4))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   hazard_scoreboard #(.DEPTH(DEPTH), .FWD_EN(1), .MEM_WIN(2), .BR_SHADOW(1), .CNT_W(16))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   int vectors = 0;
   int miscompares = 0;

   // reference model state: index 0 of each queue is the youngest in-flight instruction
   rec_t q0[$];
   rec_t q1[$];
   int   shad[2];
   int   scnt[2];
   int   cmax[2];
   int   brs[2];

   logic        o_st[2];
   logic        o_sq[2];
   logic        o_bb[2];
   logic [15:0] o_cnt[2];

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic stim_t f_nop();
      stim_t s;
      s = '{iv:0, rs:0, rsu:0, rt:0, rtu:0, rd:0, wr:0, ld:0, st:0, addr:0, ctrl:0, fl:0};
      return s;
   endfunction

   function automatic stim_t f_alu(input int rd, input int rs, input int rt,
                                   input bit rsu, input bit rtu);
      stim_t s = f_nop();
      s.iv = 1; s.rd = rd; s.wr = 1; s.rs = rs; s.rsu = rsu; s.rt = rt; s.rtu = rtu;
      return s;
   endfunction

   function automatic stim_t f_ld(input int rd, input int rs, input int addr);
      stim_t s = f_alu(rd, rs, 0, 1, 0);
      s.ld = 1; s.addr = addr;
      return s;
   endfunction

   function automatic stim_t f_st(input int rs, input int rt, input int addr);
      stim_t s = f_nop();
      s.iv = 1; s.rs = rs; s.rsu = 1; s.rt = rt; s.rtu = 1; s.st = 1; s.addr = addr;
      return s;
   endfunction

   function automatic stim_t f_br(input int rs, input int rt);
      stim_t s = f_nop();
      s.iv = 1; s.rs = rs; s.rsu = 1; s.rt = rt; s.rtu = 1; s.ctrl = 1;
      return s;
   endfunction

   function automatic vec_t mkv(input stim_t s, input bit st0, input bit sq0, input bit st1,
                                input bit sq1, input int c0, input int c1);
      vec_t v;
      v.s = s; v.st0 = st0; v.sq0 = sq0; v.st1 = st1; v.sq1 = sq1; v.c0 = c0; v.c1 = c1;
      return v;
   endfunction

   // Decision rules: RAW against any in-flight writer (or only a load in the youngest slot
   // when forwarding), store->load address match within the two youngest, shadow squash.
   function automatic void predict(input rec_t q[$], input bit fwd, input stim_t s,
                                   input int sh, output bit st, output bit sq);
      bit rh = 0;
      bit mh = 0;
      for (int k = 0; k < q.size(); k++) begin
         if (q[k].valid && q[k].wr && (!fwd || (k == 0 && q[k].ld))) begin
            if (s.rsu && q[k].rd == s.rs) rh = 1;
            if (s.rtu && q[k].rd == s.rt) rh = 1;
         end
         if (k < 2 && s.ld && q[k].valid && q[k].st && q[k].addr == s.addr) mh = 1;
      end
      sq = s.iv && (sh != 0) && !s.fl;
      st = s.iv && !sq && !s.fl && (rh || mh);
   endfunction

   function automatic void advance(input int c, input stim_t s, input bit st, input bit sq);
      rec_t r;
      bit acc;
      acc = s.iv && !st && !sq && !s.fl;
      r = '{valid:0, rd:0, wr:0, ld:0, st:0, addr:0};
      if (acc) r = '{valid:1, rd:s.rd, wr:s.wr, ld:s.ld, st:s.st, addr:s.addr};
      if (st && scnt[c] < cmax[c]) scnt[c]++;
      if (s.fl) shad[c] = 0;
      else if (acc && s.ctrl) shad[c] = brs[c];
      else if (shad[c] > 0) shad[c]--;
      if (c == 0) begin
         if (s.fl) q0.delete();
         else begin
            q0.push_front(r);
            if (q0.size() > DEPTH) void'(q0.pop_back());
         end
      end else begin
         if (s.fl) q1.delete();
         else begin
            q1.push_front(r);
            if (q1.size() > DEPTH) void'(q1.pop_back());
         end
      end
   endfunction

   function automatic void model_reset();
      q0.delete(); q1.delete();
      shad[0] = 0; shad[1] = 0; scnt[0] = 0; scnt[1] = 0;
   endfunction

   task automatic drive(input stim_t s);
      if0.issue_valid = s.iv;   if1.issue_valid = s.iv;
      if0.rs_idx = 3'(s.rs);    if1.rs_idx = 3'(s.rs);
      if0.rs_used = s.rsu;      if1.rs_used = s.rsu;
      if0.rt_idx = 3'(s.rt);    if1.rt_idx = 3'(s.rt);
      if0.rt_used = s.rtu;      if1.rt_used = s.rtu;
      if0.rd_idx = 3'(s.rd);    if1.rd_idx = 3'(s.rd);
      if0.rd_wr = s.wr;         if1.rd_wr = s.wr;
      if0.is_load = s.ld;       if1.is_load = s.ld;
      if0.is_store = s.st;      if1.is_store = s.st;
      if0.mem_addr = 16'(s.addr); if1.mem_addr = 16'(s.addr);
      if0.is_ctrl = s.ctrl;     if1.is_ctrl = s.ctrl;
      if0.flush = s.fl;         if1.flush = s.fl;
   endtask

   // Called just after a falling edge; samples mid-cycle and returns after the next one.
   task automatic cycle(input stim_t s);
      bit pst0, psq0, pst1, psq1;
      drive(s);
      #1;
      predict(q0, 1'b0, s, shad[0], pst0, psq0);
      predict(q1, 1'b1, s, shad[1], pst1, psq1);
      o_st[0] = if0.stall; o_sq[0] = if0.squash; o_bb[0] = if0.bubble; o_cnt[0] = 16'(if0.stall_cnt);
      o_st[1] = if1.stall; o_sq[1] = if1.squash; o_bb[1] = if1.bubble; o_cnt[1] = if1.stall_cnt;
      chk("m0_stall",  32'(if0.stall),     32'(pst0));
      chk("m0_squash", 32'(if0.squash),    32'(psq0));
      chk("m0_bubble", 32'(if0.bubble),    32'(pst0 | psq0));
      chk("m0_cnt",    32'(if0.stall_cnt), 32'(scnt[0]));
      chk("m1_stall",  32'(if1.stall),     32'(pst1));
      chk("m1_squash", 32'(if1.squash),    32'(psq1));
      chk("m1_bubble", 32'(if1.bubble),    32'(pst1 | psq1));
      chk("m1_cnt",    32'(if1.stall_cnt), 32'(scnt[1]));
      advance(0, s, pst0, psq0);
      advance(1, s, pst1, psq1);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(f_nop());
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      stim_t s, rdr1, rdr2, lda;
      cmax[0] = 15; cmax[1] = 65535; brs[0] = 2; brs[1] = 1;
      model_reset();
      drive(f_alu(4, 3, 0, 1, 0));
      #2;
      chk("rst_stall0",  32'(if0.stall),     0);
      chk("rst_squash0", 32'(if0.squash),    0);
      chk("rst_bubble0", 32'(if0.bubble),    0);
      chk("rst_cnt0",    32'(if0.stall_cnt), 0);
      chk("rst_cnt1",    32'(if1.stall_cnt), 0);
      do_reset();

      rdr1 = f_alu(4, 3, 0, 1, 0);
      rdr2 = f_alu(5, 0, 2, 0, 1);
      lda  = f_ld(7, 1, 'h40);
      tbl.push_back(mkv(f_alu(3, 1, 2, 1, 1), 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 4; i++) tbl.push_back(mkv(rdr1, 1, 0, 0, 0, i, 0));
      tbl.push_back(mkv(rdr1, 0, 0, 0, 0, 4, 0));
      tbl.push_back(mkv(f_ld(2, 1, 'h80), 0, 0, 0, 0, 4, 0));
      tbl.push_back(mkv(rdr2, 1, 0, 1, 0, 4, 0));
      tbl.push_back(mkv(rdr2, 1, 0, 0, 0, 5, 1));
      tbl.push_back(mkv(rdr2, 1, 0, 0, 0, 6, 1));
      tbl.push_back(mkv(rdr2, 1, 0, 0, 0, 7, 1));
      tbl.push_back(mkv(rdr2, 0, 0, 0, 0, 8, 1));
      tbl.push_back(mkv(f_alu(2, 1, 0, 1, 0), 0, 0, 0, 0, 8, 1));
      tbl.push_back(mkv(rdr2, 1, 0, 0, 0, 8, 1));
      for (int i = 0; i < 4; i++) tbl.push_back(mkv(f_nop(), 0, 0, 0, 0, 9, 1));
      tbl.push_back(mkv(f_st(1, 6, 'h40), 0, 0, 0, 0, 9, 1));
      tbl.push_back(mkv(lda, 1, 0, 1, 0, 9, 1));
      tbl.push_back(mkv(lda, 1, 0, 1, 0, 10, 2));
      tbl.push_back(mkv(lda, 0, 0, 0, 0, 11, 3));
      tbl.push_back(mkv(f_st(1, 6, 'h40), 0, 0, 0, 0, 11, 3));
      tbl.push_back(mkv(f_ld(7, 1, 'h42), 0, 0, 0, 0, 11, 3));

      foreach (tbl[i]) begin
         cycle(tbl[i].s);
         chk($sformatf("tbl%0d_stall0", i),  32'(o_st[0]), 32'(tbl[i].st0));
         chk($sformatf("tbl%0d_squash0", i), 32'(o_sq[0]), 32'(tbl[i].sq0));
         chk($sformatf("tbl%0d_bubble0", i), 32'(o_bb[0]), 32'(tbl[i].st0 | tbl[i].sq0));
         chk($sformatf("tbl%0d_stall1", i),  32'(o_st[1]), 32'(tbl[i].st1));
         chk($sformatf("tbl%0d_squash1", i), 32'(o_sq[1]), 32'(tbl[i].sq1));
         chk($sformatf("tbl%0d_cnt0", i),    32'(o_cnt[0]), 32'(tbl[i].c0));
         chk($sformatf("tbl%0d_cnt1", i),    32'(o_cnt[1]), 32'(tbl[i].c1));
      end

      // branch shadow: two squashed slots in dut0, one in dut1
      do_reset();
      cycle(f_br(1, 6));
      chk("br_accept_sq0", 32'(o_sq[0]), 0);
      chk("br_accept_st0", 32'(o_st[0]), 0);
      cycle(f_alu(5, 1, 0, 1, 0));
      chk("br_sh1_sq0", 32'(o_sq[0]), 1);
      chk("br_sh1_bb0", 32'(o_bb[0]), 1);
      chk("br_sh1_st0", 32'(o_st[0]), 0);
      chk("br_sh1_sq1", 32'(o_sq[1]), 1);
      cycle(f_alu(5, 1, 0, 1, 0));
      chk("br_sh2_sq0", 32'(o_sq[0]), 1);
      chk("br_sh2_sq1", 32'(o_sq[1]), 0);
      cycle(f_alu(5, 1, 0, 1, 0));
      chk("br_sh3_sq0", 32'(o_sq[0]), 0);
      chk("br_sh3_bb0", 32'(o_bb[0]), 0);

      // flush overrides a pending hazard and empties the scoreboard
      do_reset();
      cycle(f_alu(3, 1, 2, 1, 1));
      s = rdr1; s.fl = 1;
      cycle(s);
      chk("fl_stall0",  32'(o_st[0]), 0);
      chk("fl_bubble0", 32'(o_bb[0]), 0);
      chk("fl_squash0", 32'(o_sq[0]), 0);
      cycle(rdr1);
      chk("fl_after_stall0", 32'(o_st[0]), 0);

      // 20 stall cycles into a 4-bit counter, then async reset mid-stall
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cycle(f_alu(3, 1, 2, 1, 1));
         for (int j = 0; j < 5; j++) cycle(rdr1);
      end
      cycle(f_alu(3, 1, 2, 1, 1));
      chk("sat_cnt0", 32'(o_cnt[0]), 32'hF);
      drive(rdr1);
      #1;
      chk("async_pre_stall0", 32'(if0.stall), 1);
      rst_n = 1'b0;
      #1;
      chk("async_stall0",  32'(if0.stall),     0);
      chk("async_bubble0", 32'(if0.bubble),    0);
      chk("async_squash0", 32'(if0.squash),    0);
      chk("async_cnt0",    32'(if0.stall_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // randomized traffic against the reference model
      for (int n = 0; n < 800; n++) begin
         int kind;
         s = f_nop();
         s.iv  = ($urandom_range(0, 3) != 0);
         s.rs  = $urandom_range(0, 7); s.rsu = $urandom_range(0, 1);
         s.rt  = $urandom_range(0, 7); s.rtu = $urandom_range(0, 1);
         s.rd  = $urandom_range(0, 7);
         s.addr = 2 * $urandom_range(0, 3);
         kind = $urandom_range(0, 4);
         case (kind)
            0: s.wr = 1;
            1: begin s.ld = 1; s.wr = 1; end
            2: s.st = 1;
            3: s.ctrl = 1;
            default: s.wr = $urandom_range(0, 1);
         endcase
         s.fl = ($urandom_range(0, 15) == 0);
         cycle(s);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
